decode_scan: RTL and testbench

Parametrised registered N-to-2^N one-hot decoder with enable and an auto-scan mode. In DIRECT mode it registers the decode of the select input. In SCAN mode it sweeps the one-hot output across all 2^N lines at a programmable dwell rate. It is the next-generation select/strobe source for display digit drivers, row scanners and bank selects, replacing fixed 2-to-4 combinational decoders.

---
 rtl/decode_pkg.sv | 7 +
 rtl/decode_onehot.sv | 14 +
 rtl/decode_scan.sv | 55 +++++
 tb/tb_decode_scan.sv | 109 ++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: state encoding and one-hot line test shared by the decode_scan slice.
package decode_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DIRECT = 2'd1, SCAN = 2'd2} state_e;
  function automatic logic onehot(input int unsigned idx, input int unsigned line);
    return idx == line;
  endfunction
endpackage

// File: rtl/decode_onehot.sv
// decode_onehot: combinational N-to-2^N one-hot decoder with enable.
module decode_onehot
  import decode_pkg::*;
#(
  parameter int N = 2
) (
  input  logic              en,
  input  logic [N-1:0]      a,
  output logic [2**N-1:0]   y
);
  for (genvar i = 0; i < 2**N; i++) begin : g_line
    assign y[i] = en & onehot(int'(a), i);
  end
endmodule

// File: rtl/decode_scan.sv
// decode_scan: registered one-hot decoder with DIRECT and auto-SCAN modes.
// Define DECODE_ACTIVE_LOW_EN to drive Y active-low (all-ones when idle).
module decode_scan
  import decode_pkg::*;
#(
  parameter int N     = 2,
  parameter int DWELL = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            E,
  input  logic            MODE,
  input  logic [N-1:0]    A,
  output logic [2**N-1:0] Y,
  output logic [N-1:0]    IDX,
  output logic            WRAP
);
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
  state_e state_q, state_d;
  logic [N-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wrap_q, wrap_d, steady, step;
  logic [2**N-1:0] y_hi;
  // Only an uninterrupted SCAN cycle advances; any other enabled cycle reloads from A.
  always_comb begin
    steady  = E && MODE && state_q == SCAN;
    step    = steady && cnt_q == LAST;
    state_d = !E ? IDLE : !MODE ? DIRECT : SCAN;
    idx_d   = !E ? idx_q : !steady ? A : step ? idx_q + N'(1) : idx_q;
    cnt_d   = steady && !step ? cnt_q + CW'(1) : '0;
    wrap_d  = step && idx_q == '1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end
  decode_onehot #(.N(N)) u_dec (.en(state_q != IDLE), .a(idx_q), .y(y_hi));
`ifdef DECODE_ACTIVE_LOW_EN
  assign Y = ~y_hi;
`else
  assign Y = y_hi;
`endif
  assign IDX  = idx_q;
  assign WRAP = wrap_q;
endmodule

// File: tb/tb_decode_scan.sv
// tb_decode_scan: table vectors, DWELL=1 sweep and random traffic against a cycle model.
module tb_decode_scan;
`ifdef DECODE_ACTIVE_LOW_EN
  localparam bit AL = 1'b1;
`else
  localparam bit AL = 1'b0;
`endif
  localparam int W = 4;
  logic clk = 0, rst_n = 0, e = 0, mode = 0;
  logic [1:0] a = 0;
  logic [3:0] y3, y1;
  logic [1:0] idx3, idx1;
  logic wrap3, wrap1;
  decode_scan #(.N(2), .DWELL(3)) u3 (.clk(clk), .rst_n(rst_n), .E(e), .MODE(mode), .A(a), .Y(y3), .IDX(idx3), .WRAP(wrap3));
  decode_scan #(.N(2), .DWELL(1)) u1 (.clk(clk), .rst_n(rst_n), .E(e), .MODE(mode), .A(a), .Y(y1), .IDX(idx1), .WRAP(wrap1));
  always #5 clk = ~clk;
  int vecs = 0, errs = 0;
  bit m_on[2], m_scan[2], m_wrap[2];
  int m_idx[2], m_held[2];
  int dw[2] = '{3, 1};
  typedef struct {bit r; bit e; bit m; bit [1:0] a; bit [3:0] y; bit [1:0] i; bit w;} row_t;
  row_t tbl[$];
  task automatic add(bit r, bit en, bit m, bit [1:0] av, bit [3:0] y, bit [1:0] i, bit w, int n = 1);
    row_t t;
    t = '{r, en, m, av, y, i, w};
    for (int k = 0; k < n; k++) tbl.push_back(t);
  endtask
  function automatic logic [3:0] vis(logic [3:0] v);
    return AL ? ~v : v;
  endfunction
  // Model: a scan index is shown for DWELL cycles, then moves on; a move onto 0 raises WRAP.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_wrap[k] = 0;
      if (!rst_n) begin m_on[k] = 0; m_scan[k] = 0; m_idx[k] = 0; end
      else if (!e) begin m_on[k] = 0; m_scan[k] = 0; end
      else if (!mode) begin m_on[k] = 1; m_scan[k] = 0; m_idx[k] = int'(a); end
      else if (!m_scan[k]) begin m_on[k] = 1; m_scan[k] = 1; m_idx[k] = int'(a); m_held[k] = 1; end
      else if (m_held[k] == dw[k]) begin
        m_idx[k] = (m_idx[k] + 1) % W; m_held[k] = 1; m_wrap[k] = m_idx[k] == 0;
      end else m_held[k]++;
    end
  endtask
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic tick();
    logic [3:0] ey[2];
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < 2; k++) ey[k] = vis(m_on[k] ? 4'(1 << m_idx[k]) : 4'b0);
    check("model_y_dw3", 32'(y3), 32'(ey[0]));
    check("model_idx_dw3", 32'(idx3), 32'(m_idx[0]));
    check("model_wrap_dw3", 32'(wrap3), 32'(m_wrap[0]));
    check("model_y_dw1", 32'(y1), 32'(ey[1]));
    check("model_idx_dw1", 32'(idx1), 32'(m_idx[1]));
    check("model_wrap_dw1", 32'(wrap1), 32'(m_wrap[1]));
  endtask
  initial begin
    add(0, 1, 1, 0, 4'b0000, 0, 0, 2);
    add(1, 1, 0, 0, 4'b0001, 0, 0);
    add(1, 1, 0, 1, 4'b0010, 1, 0);
    add(1, 1, 0, 3, 4'b1000, 3, 0);
    add(1, 1, 0, 2, 4'b0100, 2, 0);
    add(1, 0, 0, 2, 4'b0000, 2, 0);
    add(1, 1, 1, 2, 4'b0100, 2, 0);
    add(1, 1, 1, 1, 4'b0100, 2, 0, 2);
    add(1, 1, 1, 1, 4'b1000, 3, 0, 3);
    add(1, 1, 1, 1, 4'b0001, 0, 1);
    add(1, 1, 1, 1, 4'b0001, 0, 0, 2);
    add(1, 1, 1, 3, 4'b0010, 1, 0, 3);
    add(1, 1, 1, 0, 4'b0100, 2, 0);
    add(1, 0, 1, 0, 4'b0000, 2, 0);
    add(1, 1, 1, 3, 4'b1000, 3, 0, 3);
    add(1, 1, 1, 0, 4'b0001, 0, 1);
    add(1, 1, 0, 1, 4'b0010, 1, 0);
    add(1, 1, 1, 0, 4'b0001, 0, 0, 2);
    add(0, 1, 1, 2, 4'b0000, 0, 0);
    add(1, 1, 1, 3, 4'b1000, 3, 0);
    foreach (tbl[j]) begin
      rst_n = tbl[j].r; e = tbl[j].e; mode = tbl[j].m; a = tbl[j].a;
      tick();
      check($sformatf("tbl%0d_y", j), 32'(y3), 32'(vis(tbl[j].y)));
      check($sformatf("tbl%0d_idx", j), 32'(idx3), 32'(tbl[j].i));
      check($sformatf("tbl%0d_wrap", j), 32'(wrap3), 32'(tbl[j].w));
    end
    rst_n = 0; tick();
    rst_n = 1; e = 1; mode = 1; a = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("dw1_idx%0d", i), 32'(idx1), 32'(i % 4));
      check($sformatf("dw1_wrap%0d", i), 32'(wrap1), 32'(i % 4 == 0 && i > 0));
    end
    for (int i = 0; i < 600; i++) begin
      rst_n = $urandom_range(0, 31) != 0;
      e = $urandom_range(0, 9) != 0;
      mode = $urandom_range(0, 6) != 0;
      a = 2'($urandom);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
